// File: rtl/gfx_pixel_shifter_if.sv
// Pixel shifter bus: PAL timing strobes and ROM fetch in, mixer pixel out.
// The master modport drives the fetch/timing side; the shifter is the slave.
interface gfx_pixel_shifter_if #(
  parameter int PLANES = 4,
  parameter int AW     = 4
);
  logic              Cen;
  logic [15:0]       GFX_DATA;
  logic [AW-1:0]     ATTR_IN;
  logic              VLK;
  logic              AB_Sel;
  logic              PLOAD_RSHIFTn;
  logic              RL_Sel;
  logic              VDG;
  logic [PLANES-1:0] PIX_OUT;
  logic [AW-1:0]     ATTR_OUT;
  logic              PIX_OPAQUE;
  logic              UNDERRUN;

  modport master (
    output Cen, GFX_DATA, ATTR_IN, VLK, AB_Sel, PLOAD_RSHIFTn, RL_Sel, VDG,
    input  PIX_OUT, ATTR_OUT, PIX_OPAQUE, UNDERRUN
  );

  modport slave (
    input  Cen, GFX_DATA, ATTR_IN, VLK, AB_Sel, PLOAD_RSHIFTn, RL_Sel, VDG,
    output PIX_OUT, ATTR_OUT, PIX_OPAQUE, UNDERRUN
  );
endinterface

// File: rtl/gfx_pixel_shifter.sv
// Graphics pixel shifter: latches two 16-bit ROM words into a 32-bit holding
// latch, parallel-loads four 8-bit bitplanes and serialises one 4-bit pixel
// per Cen, optionally flipped, with a registered pixel/attribute output.
// Optional macro GFX_PIXEL_SHIFTER_PIPE_EN adds a second output stage.
module gfx_pixel_shifter #(
  parameter int PLANES = 4,
  parameter int PW     = 8,
  parameter int AW     = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  gfx_pixel_shifter_if.slave   bus
);
  localparam int HW = PLANES * PW;      // holding latch / shift register width
  localparam int CW = $clog2(PW + 1);   // pixel counter must reach PW (empty)
  localparam logic [CW-1:0] CNT_EMPTY = CW'(PW);

  logic [HW-1:0]     hold;
  logic [HW-1:0]     shreg;
  logic [HW-1:0]     shl_val;
  logic [HW-1:0]     shr_val;
  logic              dir_r;
  logic [AW-1:0]     attr_hold;
  logic [AW-1:0]     attr_r;
  logic [CW-1:0]     pix_cnt;
  logic [PLANES-1:0] head;
  logic [PLANES-1:0] pix_next;
  logic              load;

  logic [PLANES-1:0] pix_s1;
  logic [AW-1:0]     attr_s1;
  logic              opaque_s1;
  logic              underrun_s1;

  assign load = ~bus.PLOAD_RSHIFTn;

  // Per-plane head pixel and zero-filled shifted views of the shift register
  genvar gi;
  generate
    for (gi = 0; gi < PLANES; gi++) begin : g_plane
      assign head[gi] = dir_r ? shreg[gi*PW] : shreg[gi*PW + PW - 1];
      assign shl_val[gi*PW +: PW] = {shreg[gi*PW +: PW-1], 1'b0};
      assign shr_val[gi*PW +: PW] = {1'b0, shreg[gi*PW + 1 +: PW-1]};
    end
  endgenerate

  // Gate the head pixel: transparent when video is blanked or the group is spent
  assign pix_next = (bus.VDG && (pix_cnt < CNT_EMPTY)) ? head : '0;

  // Holding latch: two ROM strobes per group, attribute rides with the high half
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold      <= '0;
      attr_hold <= '0;
    end else if (bus.Cen && bus.VLK) begin
      if (bus.AB_Sel) begin
        hold[HW-1 -: 16] <= bus.GFX_DATA;
        attr_hold        <= bus.ATTR_IN;
      end else begin
        hold[15:0] <= bus.GFX_DATA;
      end
    end
  end

  // Shift register: load snapshots the old latch contents and the flip direction
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shreg   <= '0;
      dir_r   <= 1'b0;
      attr_r  <= '0;
      pix_cnt <= CNT_EMPTY;
    end else if (bus.Cen) begin
      if (load) begin
        shreg   <= hold;
        dir_r   <= bus.RL_Sel;
        attr_r  <= attr_hold;
        pix_cnt <= '0;
      end else begin
        shreg <= dir_r ? shr_val : shl_val;
        if (pix_cnt != CNT_EMPTY) begin
          pix_cnt <= pix_cnt + 1'b1;
        end
      end
    end
  end

  // First output stage; underrun is sticky from a shift past empty until reload
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pix_s1      <= '0;
      attr_s1     <= '0;
      opaque_s1   <= 1'b0;
      underrun_s1 <= 1'b0;
    end else if (bus.Cen) begin
      pix_s1    <= pix_next;
      attr_s1   <= attr_r;
      opaque_s1 <= |pix_next;
      if (load) begin
        underrun_s1 <= 1'b0;
      end else if (pix_cnt == CNT_EMPTY) begin
        underrun_s1 <= 1'b1;
      end
    end
  end

`ifdef GFX_PIXEL_SHIFTER_PIPE_EN
  logic [PLANES-1:0] pix_s2;
  logic [AW-1:0]     attr_s2;
  logic              opaque_s2;
  logic              underrun_s2;

  // Second output stage for timing closure towards the mixer
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pix_s2      <= '0;
      attr_s2     <= '0;
      opaque_s2   <= 1'b0;
      underrun_s2 <= 1'b0;
    end else if (bus.Cen) begin
      pix_s2      <= pix_s1;
      attr_s2     <= attr_s1;
      opaque_s2   <= opaque_s1;
      underrun_s2 <= underrun_s1;
    end
  end

  assign bus.PIX_OUT    = pix_s2;
  assign bus.ATTR_OUT   = attr_s2;
  assign bus.PIX_OPAQUE = opaque_s2;
  assign bus.UNDERRUN   = underrun_s2;
`else
  assign bus.PIX_OUT    = pix_s1;
  assign bus.ATTR_OUT   = attr_s1;
  assign bus.PIX_OPAQUE = opaque_s1;
  assign bus.UNDERRUN   = underrun_s1;
`endif

endmodule

// File: tb/tb_gfx_pixel_shifter.sv
// Directed table-driven bench for gfx_pixel_shifter. Each record is one Cen
// step with hand-computed outputs expected right after that edge.
module tb_gfx_pixel_shifter;
  logic clk;
  logic reset;

  gfx_pixel_shifter_if #(.PLANES(4), .AW(4)) bus ();

  gfx_pixel_shifter #(.PLANES(4), .PW(8), .AW(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         idle;     // Cen-low clocks inserted before this step
    logic       vlk;
    logic       ab;
    logic [15:0] data;
    logic [3:0] attr;
    logic       pl_n;
    logic       rl;
    logic       vdg;
    logic [3:0] e_pix;
    logic [3:0] e_attr;
    logic       e_und;
  } vec_t;

  typedef struct {
    logic [3:0] pix;
    logic [3:0] attr;
    logic       opq;
    logic       und;
  } exp_t;

  vec_t vecs[$];
  exp_t shown;      // what the outputs should currently show
  exp_t stage;      // first-stage value, used when the extra pipe is built
  int   n_cmp = 0;
  int   n_bad = 0;
  int   step_no = 0;

  task automatic add(input int idle, input int vlk, input int ab, input int d,
                     input int a, input int pl_n, input int rl, input int vdg,
                     input int ep, input int ea, input int eu);
    vec_t v;
    v.idle = idle;       v.vlk = (vlk != 0);   v.ab = (ab != 0);
    v.data = 16'(d);     v.attr = 4'(a);       v.pl_n = (pl_n != 0);
    v.rl = (rl != 0);    v.vdg = (vdg != 0);   v.e_pix = 4'(ep);
    v.e_attr = 4'(ea);   v.e_und = (eu != 0);
    vecs.push_back(v);
  endtask

  // Eight shift steps; pat holds the expected pixels, first pixel in the top nibble
  task automatic add_group(input logic [31:0] pat, input int ea, input int vdg_mask,
                           input int rl_pat, input int idle_at);
    for (int i = 0; i < 8; i++) begin
      add((i == idle_at) ? 3 : 0, 0, 0, 0, 0, 1, (rl_pat >> i) & 1,
          (vdg_mask >> i) & 1, int'(pat[31-4*i -: 4]), ea, 0);
    end
  endtask

  task automatic check(input exp_t w, input string name);
    n_cmp++;
    if (bus.PIX_OUT !== w.pix || bus.ATTR_OUT !== w.attr ||
        bus.PIX_OPAQUE !== w.opq || bus.UNDERRUN !== w.und) begin
      n_bad++;
      $display("FAIL %s step %0d: got pix=%h attr=%h opq=%b und=%b, want pix=%h attr=%h opq=%b und=%b",
               name, step_no, bus.PIX_OUT, bus.ATTR_OUT, bus.PIX_OPAQUE, bus.UNDERRUN,
               w.pix, w.attr, w.opq, w.und);
    end
  endtask

  task automatic run_step(input vec_t v);
    exp_t cur;
    exp_t want;
    repeat (v.idle) begin
      @(negedge clk);
      check(shown, "cen_low_hold");
    end
    @(negedge clk);
    bus.VLK = v.vlk;  bus.AB_Sel = v.ab;   bus.GFX_DATA = v.data;
    bus.ATTR_IN = v.attr; bus.PLOAD_RSHIFTn = v.pl_n; bus.RL_Sel = v.rl;
    bus.VDG = v.vdg;  bus.Cen = 1'b1;
    @(posedge clk);
    #1;
    bus.Cen = 1'b0;
    bus.VLK = 1'b0;
    cur.pix = v.e_pix; cur.attr = v.e_attr; cur.opq = (v.e_pix != 4'h0); cur.und = v.e_und;
`ifdef GFX_PIXEL_SHIFTER_PIPE_EN
    want  = stage;
    stage = cur;
`else
    want = cur;
`endif
    check(want, "step");
    $display("step %0d: pload_n=%b vlk=%b vdg=%b -> pix=%h attr=%h opq=%b und=%b",
             step_no, v.pl_n, v.vlk, v.vdg, bus.PIX_OUT, bus.ATTR_OUT,
             bus.PIX_OPAQUE, bus.UNDERRUN);
    shown = want;
    step_no++;
  endtask

  task automatic run_all();
    foreach (vecs[i]) run_step(vecs[i]);
    vecs.delete();
  endtask

  initial begin
    exp_t zero;
    zero = '{pix: 4'h0, attr: 4'h0, opq: 1'b0, und: 1'b0};
    shown = zero;
    stage = zero;
    bus.Cen = 1'b0; bus.VLK = 1'b0; bus.AB_Sel = 1'b0; bus.GFX_DATA = 16'h0;
    bus.ATTR_IN = 4'h0; bus.PLOAD_RSHIFTn = 1'b1; bus.RL_Sel = 1'b0; bus.VDG = 1'b1;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check(zero, "in_reset");
    reset = 1'b0;
    // Reset then no Cen for 10 clocks: outputs stay cleared
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i == 0 || i == 9) check(zero, "reset_idle");
    end

    // Shifting an empty shifter after reset flags underrun immediately
    add(0, 0, 0, 0,       0,   1, 0, 1, 0, 0,   1);
    add(0, 1, 0, 'h0F81,  0,   1, 0, 1, 0, 0,   1);
    add(0, 1, 1, 'h0000,  'hA, 1, 0, 1, 0, 0,   1);
    add(0, 0, 0, 0,       0,   0, 0, 1, 0, 0,   0);   // load, unflipped
    add_group(32'h1000_2223, 'hA, 'hFF, 'h00, -1);
    add(0, 0, 0, 0,       0,   1, 0, 1, 0, 'hA, 1);   // ninth shift
    add(0, 0, 0, 0,       0,   0, 1, 1, 0, 'hA, 0);   // load, flipped
    add_group(32'h3222_0001, 'hA, 'hFF, 'h55, -1);    // RL_Sel toggles, ignored
    add(0, 1, 0, 'h0000,  0,   1, 0, 1, 0, 'hA, 1);
    add(0, 1, 1, 'h0000,  5,   1, 0, 1, 0, 'hA, 1);   // hold now all zero
    add(0, 1, 0, 'hFFFF,  0,   0, 0, 1, 0, 'hA, 0);   // load old zero + capture
    add(0, 1, 1, 'hFFFF,  7,   1, 0, 1, 0, 5,   0);
    for (int i = 0; i < 7; i++) add(0, 0, 0, 0, 0, 1, 0, 1, 0, 5, 0);
    add(0, 0, 0, 0,       0,   0, 0, 1, 0, 5,   0);   // load 32'hFFFFFFFF
    add_group(32'hFF0F_FFFF, 7, 'hFB, 'h00, 3);       // VDG low on pixel 3, Cen gap
    add(0, 0, 0, 0,       0,   1, 0, 1, 0, 7,   1);
    add(0, 0, 0, 0,       0,   0, 0, 1, 0, 7,   0);   // reload clears underrun
    add(0, 1, 0, 'h0181,  0,   1, 0, 1, 'hF, 7, 0);
    add(0, 1, 1, 'h0000,  3,   1, 0, 1, 'hF, 7, 0);
    for (int i = 0; i < 6; i++) add(0, 0, 0, 0, 0, 1, 0, 1, 'hF, 7, 0);
    add(0, 0, 0, 0,       0,   0, 0, 1, 0, 7,   0);   // load 0181 group
    add_group(32'h1000_0003, 3, 'hFF, 'h00, -1);
    // Mid-line reset sequence: bright group, three pixels, then reset
    add(0, 1, 0, 'hFFFF,  0,   1, 0, 1, 0, 3,   1);
    add(0, 1, 1, 'hFFFF,  9,   1, 0, 1, 0, 3,   1);
    add(0, 0, 0, 0,       0,   0, 0, 1, 0, 3,   0);
    for (int i = 0; i < 3; i++) add(0, 0, 0, 0, 0, 1, 0, 1, 'hF, 9, 0);
    run_all();

    // Reset between edges must clear outputs without any clock edge
    @(negedge clk);
    #1 reset = 1'b1;
    #1 check(zero, "async_reset");
    repeat (2) @(negedge clk);
    reset = 1'b0;
    shown = zero;
    stage = zero;

    // After reset: empty shifter, cleared latch and attribute
    add(0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 1);
    add(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    add(0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0);
    add(0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0);
    run_all();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete, want completion");
    $fatal(1, "timeout");
  end
endmodule
